// File: rtl/audio_pkg.sv
// Shared constants for the 8-bit audio path (waveform generators and the PWM DAC).
// No logic: sample width, idle level, PWM step count and default clock divider.
package audio_pkg;
    localparam int                  SAMPLE_W        = 8;
    localparam int                  PWM_STEPS       = 256;
    localparam int                  CLK_DIV_DEFAULT = 4;
    localparam logic [SAMPLE_W-1:0] IDLE_LEVEL      = 8'h80;
endpackage

// File: rtl/pwm_tick_divider.sv
// Phase-step prescaler: tick pulses once every CLK_DIV clocks while run is high.
// Combinational tick from the counter; dropping run clears the count on the next edge.
module pwm_tick_divider
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!run || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = run && (r_count == LAST);
endmodule

// File: rtl/pwm_audio_dac.sv
// One-sample-per-period PWM DAC with a single shadow buffer, period strobe and sticky underrun.
// Sample reaches pwm_out one edge after the next boundary; sample_ready drops while the shadow is full.
module pwm_audio_dac #(
    parameter int                                    CLK_DIV    = audio_pkg::CLK_DIV_DEFAULT,
    parameter int                                    SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter logic [SAMPLE_W-1:0]                   IDLE_LEVEL = audio_pkg::IDLE_LEVEL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                underrun_clr,
    output logic                pwm_out,
    output logic                aud_sd,
    output logic                period_start,
    output logic                underrun
);
    logic                r_running;
    logic                r_shadow_full;
    logic [SAMPLE_W-1:0] r_phase;
    logic [SAMPLE_W-1:0] r_shadow;
    logic [SAMPLE_W-1:0] r_active;

    logic w_tick;
    logic w_stop;
    logic w_start;
    logic w_wrap;
    logic w_boundary;
    logic w_accept;

    // Prescaler runs only while running and still enabled, so a stop clears it on the same edge.
    pwm_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .run   (r_running && enable),
        .tick  (w_tick)
    );

    assign w_stop       = r_running && !enable;
    assign w_start      = enable && !r_running;
    assign w_wrap       = w_tick && (&r_phase);
    assign w_boundary   = w_start || w_wrap;
    assign w_accept     = sample_valid && !r_shadow_full;
    assign sample_ready = !r_shadow_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_running     <= 1'b0;
            r_shadow_full <= 1'b0;
            r_phase       <= '0;
            r_shadow      <= '0;
            r_active      <= IDLE_LEVEL;
            pwm_out       <= 1'b0;
            aud_sd        <= 1'b0;
            period_start  <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            pwm_out      <= r_running && (r_phase < r_active);
            aud_sd       <= r_running;
            period_start <= w_boundary;
            underrun     <= (w_boundary && !r_shadow_full) || (underrun && !underrun_clr);

            if (w_stop) begin
                // A sample offered on the stopping edge is discarded along with the shadow.
                r_running     <= 1'b0;
                r_phase       <= '0;
                r_shadow_full <= 1'b0;
                r_active      <= IDLE_LEVEL;
            end else begin
                if (w_start) begin
                    r_running <= 1'b1;
                    r_phase   <= '0;
                end else if (w_tick) begin
                    r_phase <= r_phase + 1'b1;
                end

                // Boundary consumes the pre-edge shadow; a same-edge accept refills it afterwards.
                if (w_boundary && r_shadow_full) begin
                    r_active      <= r_shadow;
                    r_shadow_full <= 1'b0;
                end
                if (w_accept) begin
                    r_shadow      <= sample;
                    r_shadow_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/pwm_audio_dac.md
Name: pwm_audio_dac

Overview:
- Downstream consumer of the 8-bit waveform generators (sawtooth, and later others).
- Converts one unsigned 8-bit sample per PWM period into a single-bit PWM stream for the board's mono audio amplifier, and drives the amplifier shutdown pin.
- Buffers one sample via valid/ready and pulses a period strobe so the upstream generator can pace itself.
- Flags underrun when a period starts with no fresh sample.

Parameters:
- CLK_DIV, 4, system clocks per PWM phase step (>=1); PWM period = 256*CLK_DIV clocks (97.66 kHz at 100 MHz).
- SAMPLE_W, 8, sample width; phase counter width equals SAMPLE_W.
- IDLE_LEVEL, 8'h80, reset/disabled value of the active duty register (midscale).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  run request, sampled synchronously.
- sample  in  SAMPLE_W  unsigned duty value from upstream generator.
- sample_valid  in  1  sample is presented.
- sample_ready  out  1  shadow buffer empty; a transfer occurs when valid && ready at a clock edge.
- underrun_clr  in  1  clears sticky underrun.
- pwm_out  out  1  PWM data; top level maps 1 to high-Z and 0 to drive-low.
- aud_sd  out  1  amplifier enable, registered; 1 = amplifier on.
- period_start  out  1  one-cycle pulse, registered, following each period boundary.
- underrun  out  1  sticky underrun flag.

Behaviour:
- Reset values: running=0, prescaler=0, phase=0, shadow_full=0, active=IDLE_LEVEL, pwm_out=0, aud_sd=0, period_start=0, underrun=0.
- sample_ready = !shadow_full (combinational from the flag). It is high after reset, including while disabled.
- Accept: when valid && ready, shadow <= sample and shadow_full <= 1.
- Prescaler: counts 0..CLK_DIV-1 while running. tick = running && prescaler==CLK_DIV-1. With CLK_DIV=1, tick is high every running cycle.
- Phase: increments on tick and wraps 255 -> 0.
- Boundary events:
  - Start: enable=1 && running=0. Sets running<=1, phase<=0, prescaler<=0.
  - Wrap: tick && phase==255.
- At every boundary edge:
  - If shadow_full: active <= shadow, shadow_full <= 0.
  - Else: active holds, underrun <= 1.
  - period_start <= 1 on the next cycle only.
- Boundary and accept in the same cycle: the boundary uses the shadow contents from before the edge. The newly accepted sample stays in shadow for the next period (no bypass). If the shadow was empty, underrun is set.
- underrun: sticky. underrun_clr clears it. If set and clear coincide, set wins.
- pwm_out(t+1) = running(t) && (phase(t) < active(t)).
  - active=0: never high.
  - active=255: high 255 of 256 phase steps.
  - Duty = active/256.
- aud_sd(t+1) = running(t).
- Disable: enable=0 while running gives on the next edge running=0, prescaler=0, phase=0, shadow_full=0 (flushed), active=IDLE_LEVEL. pwm_out and aud_sd fall one cycle later. Holds mid-period.
- Latency:
  - Sample accepted at edge N is loaded into active at the next boundary B.
  - The first pwm_out bit using it appears at edge B+1.
  - Start-to-first-PWM-bit is 1 cycle after running rises.
- Asynchronous reset mid-period forces all outputs low immediately. No output glitch is generated by the block beyond the reset itself.

Decomposition:
- Shared package audio_pkg: SAMPLE_W, IDLE_LEVEL, PWM_STEPS=256, default CLK_DIV. Reused by the waveform generators.
- One sub-module, pwm_tick_divider: CLK_DIV parameter; inputs clk, reset, run; output tick.
- Shadow, phase, compare and flag logic stay in the top module.

Test Plan:
- CLK_DIV=1, enable=1, feed 0x40 before each boundary -> pwm_out high exactly 64 of every 256 cycles; period_start every 256 cycles; underrun=0.
- Samples 0x00 then 0xFF -> period 1 pwm_out constantly 0; period 2 high 255 cycles and low 1.
- Stop feeding after one sample -> at the next wrap underrun=1 and duty repeats the previous value; underrun_clr pulse -> 0; clear coinciding with a fresh underrun -> stays 1.
- Accept 0x10 then hold valid with 0x20 -> ready low until the boundary; 0x20 is accepted the cycle the shadow empties; periods show duty 16 then 32 in order.
- CLK_DIV=4, drop enable at phase 100 -> pwm_out and aud_sd low two edges later; shadow flushed (ready=1); re-enable restarts at phase 0 with active=0x80 if no sample is present.
- Assert reset asynchronously mid-period, between clock edges -> all outputs 0 before the next edge; ready=1 after release.
